// File: rtl/hz_pkg.sv
// Shared types for the hazard scoreboard: pipe entry, stage index,
// forwarding-select encoding and the forwarding-availability rule.
package hz_pkg;

  // Widest register address / stage index the scoreboard carries.
  // These cover NREG <= 64 and DEPTH <= 15.
  localparam int RD_W  = 6;
  localparam int STG_W = 4;

  typedef logic [RD_W-1:0]  reg_t;
  typedef logic [STG_W-1:0] stage_t;

  typedef struct packed {
    logic valid;
    logic we;
    logic ld;
    reg_t rd;
  } entry_t;

  // fwd_sel encoding: 0 reads the register file,
  // k selects the stage-k result bus.
  localparam stage_t FWD_RF = '0;

  function automatic int avail(
    input logic ld,
    input int   alu_lat,
    input int   load_lat
  );
    return ld ? load_lat : alu_lat;
  endfunction

endpackage

// File: rtl/hz_match.sv
// Per-operand priority matcher: youngest valid writer of rs wins.
// Ports: pipe entries, used, rs in; sel (stage or 0) and late out.
module hz_match
  import hz_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2
) (
  input  entry_t [DEPTH:1] pipe,
  input  logic             used,
  input  reg_t             rs,
  output stage_t           sel,
  output logic             late
);

  // Walk oldest to youngest so the lowest k is the last write.
  always_comb begin
    sel  = FWD_RF;
    late = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (pipe[k].valid && pipe[k].we && pipe[k].rd == rs) begin
        sel  = stage_t'(k);
        late = k < avail(pipe[k].ld, ALU_LAT, LOAD_LAT);
      end
    end
    if (!used) begin
      sel  = FWD_RF;
      late = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order hazard scoreboard: stall/bubble and forwarding selects for ID.
// Ports: clk, rst (async, active low), id_* instruction, flush in;
// stall, bubble, fwd_sel_rs1/rs2 out; stall_cycles when HAZ_STATS_EN.
module hazard_scoreboard
  import hz_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int DEPTH    = 4,
  parameter int ALU_LAT  = 1,
  parameter int LOAD_LAT = 2,
  localparam int AW      = $clog2(NREG),
  localparam int SW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic          id_rd_we,
  input  logic          id_is_load,
  input  logic [AW-1:0] id_rd,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_rs1_used,
  input  logic          id_rs2_used,
  input  logic          flush,
  output logic          stall,
  output logic          bubble,
  output logic [SW-1:0] fwd_sel_rs1,
  output logic [SW-1:0] fwd_sel_rs2
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]   stall_cycles
`endif
);

  entry_t [DEPTH:1] pipe;
  entry_t           nxt;
  stage_t           sel1;
  stage_t           sel2;
  logic             late1;
  logic             late2;
  logic             hazard;
  logic             fwd_ok;

  hz_match #(
    .DEPTH   (DEPTH),
    .ALU_LAT (ALU_LAT),
    .LOAD_LAT(LOAD_LAT)
  ) u_rs1 (
    .pipe(pipe),
    .used(id_rs1_used),
    .rs  (reg_t'(id_rs1)),
    .sel (sel1),
    .late(late1)
  );

  hz_match #(
    .DEPTH   (DEPTH),
    .ALU_LAT (ALU_LAT),
    .LOAD_LAT(LOAD_LAT)
  ) u_rs2 (
    .pipe(pipe),
    .used(id_rs2_used),
    .rs  (reg_t'(id_rs2)),
    .sel (sel2),
    .late(late2)
  );

  assign hazard = late1 | late2;
  // Flush wins over stall: the squashed instruction needs no operands.
  assign stall  = id_valid & ~flush & hazard;
  assign bubble = id_valid & (flush | hazard);
  assign fwd_ok = id_valid & ~flush & ~hazard;

  assign fwd_sel_rs1 = fwd_ok ? SW'(sel1) : '0;
  assign fwd_sel_rs2 = fwd_ok ? SW'(sel2) : '0;

  // x0 writers never match, so clear we at entry.
  always_comb begin
    nxt = '0;
    if (id_valid && !stall && !flush) begin
      nxt.valid = 1'b1;
      nxt.we    = id_rd_we & (id_rd != '0);
      nxt.ld    = id_is_load;
      nxt.rd    = reg_t'(id_rd);
    end
  end

  // Advances every cycle; a stall releases as the producer ages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe <= '0;
    end else begin
      pipe[1] <= nxt;
      for (int k = 2; k <= DEPTH; k++) begin
        pipe[k] <= pipe[k-1];
      end
    end
  end

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (stall && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed cases plus random stream,
// checked against an issue-history model.
module tb_hazard_scoreboard;

  localparam int NREG     = 32;
  localparam int DEPTH    = 4;
  localparam int ALU_LAT  = 1;
  localparam int LOAD_LAT = 2;
  localparam int AW       = $clog2(NREG);
  localparam int SW       = $clog2(DEPTH + 1);
  localparam int HMAX     = 2048;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic          id_rd_we;
  logic          id_is_load;
  logic [AW-1:0] id_rd;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_rs1_used;
  logic          id_rs2_used;
  logic          flush;
  logic          stall;
  logic          bubble;
  logic [SW-1:0] fwd_sel_rs1;
  logic [SW-1:0] fwd_sel_rs2;
`ifdef HAZ_STATS_EN
  logic [31:0]   stall_cycles;
`endif

  hazard_scoreboard #(
    .NREG    (NREG),
    .DEPTH   (DEPTH),
    .ALU_LAT (ALU_LAT),
    .LOAD_LAT(LOAD_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rd_we   (id_rd_we),
    .id_is_load (id_is_load),
    .id_rd      (id_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .flush      (flush),
    .stall      (stall),
    .bubble     (bubble),
    .fwd_sel_rs1(fwd_sel_rs1),
    .fwd_sel_rs2(fwd_sel_rs2)
`ifdef HAZ_STATS_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int base  = 0;
  int exp_sc = 0;

  // Issue history: what entered EXE at the end of each cycle.
  bit hv  [HMAX];
  bit hwe [HMAX];
  bit hld [HMAX];
  int hrd [HMAX];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Youngest earlier issue writing rs; age is the stage it sits in.
  function automatic void model(input int rs, input bit used,
                                output bit late, output int sel);
    late = 0;
    sel  = 0;
    if (!used) return;
    for (int a = 1; a <= DEPTH; a++) begin
      int c;
      c = cyc - a;
      if (c < base) return;
      if (hv[c] && hwe[c] && hrd[c] != 0 && hrd[c] == rs) begin
        sel  = a;
        late = a < (hld[c] ? LOAD_LAT : ALU_LAT);
        return;
      end
    end
  endfunction

  task automatic step(input bit v, input bit we, input bit ld,
                      input int rd, input int rs1, input int rs2,
                      input bit u1, input bit u2, input bit fl,
                      input int xs, input int xb,
                      input int x1, input int x2);
    bit l1, l2, es, eb;
    int s1, s2;
    id_valid    = v;
    id_rd_we    = we;
    id_is_load  = ld;
    id_rd       = AW'(rd);
    id_rs1      = AW'(rs1);
    id_rs2      = AW'(rs2);
    id_rs1_used = u1;
    id_rs2_used = u2;
    flush       = fl;
    @(negedge clk);
    model(rs1, u1, l1, s1);
    model(rs2, u2, l2, s2);
    es = v && !fl && (l1 || l2);
    eb = v && (fl || l1 || l2);
    chk($sformatf("c%0d stall", cyc), 32'(stall), int'(es));
    chk($sformatf("c%0d bubble", cyc), 32'(bubble), int'(eb));
    if (!v) begin
      chk($sformatf("c%0d f1idle", cyc), 32'(fwd_sel_rs1), 0);
      chk($sformatf("c%0d f2idle", cyc), 32'(fwd_sel_rs2), 0);
    end else if (!fl && !es) begin
      chk($sformatf("c%0d f1", cyc), 32'(fwd_sel_rs1), s1);
      chk($sformatf("c%0d f2", cyc), 32'(fwd_sel_rs2), s2);
    end
    if (xs >= 0) chk($sformatf("c%0d d_stall", cyc), 32'(stall), xs);
    if (xb >= 0) chk($sformatf("c%0d d_bub", cyc), 32'(bubble), xb);
    if (x1 >= 0) chk($sformatf("c%0d d_f1", cyc), 32'(fwd_sel_rs1), x1);
    if (x2 >= 0) chk($sformatf("c%0d d_f2", cyc), 32'(fwd_sel_rs2), x2);
    hv[cyc]  = v && !fl && !es;
    hwe[cyc] = we;
    hld[cyc] = ld;
    hrd[cyc] = rd;
    if (es) exp_sc++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    id_valid = 0; id_rd_we = 0; id_is_load = 0;
    id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_rs1_used = 0; id_rs2_used = 0; flush = 0;
    #2;
    chk("rst stall", 32'(stall), 0);
    chk("rst bubble", 32'(bubble), 0);
    chk("rst f1", 32'(fwd_sel_rs1), 0);
`ifdef HAZ_STATS_EN
    chk("rst sc", stall_cycles, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;

    // ALU x5 then reader of x5: forward from EXE.
    step(1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 1, 0);
    idle(4);

    // Load x7 then rs2 reader: one stall, then forward from MEM.
    step(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 8, 0, 7, 0, 1, 0, 1, 1, -1, -1);
    step(1, 1, 0, 8, 0, 7, 0, 1, 0, 0, 0, 0, 2);
    idle(4);

    // ALU x3 then load x3: the younger load decides.
    step(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 3, 0, 1, 0, 0, 1, 1, -1, -1);
    step(1, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0, 2, 0);
    idle(4);

    // x0 is never forwarded.
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    idle(4);

    // WB stage match at k=DEPTH, gone one cycle later.
    step(1, 1, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 11, 0, 1, 0, 0, 0, 0, 4, 0);
    step(1, 0, 0, 0, 0, 11, 0, 1, 0, 0, 0, 0, 0);
    idle(4);

    // Flush during load-use stall; flushed x9 writer never enters.
    step(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 9, 0, 7, 0, 1, 1, 0, 1, -1, -1);
    step(1, 0, 0, 0, 9, 7, 1, 1, 0, 0, 0, 0, 2);
    idle(4);

    // id_valid low ignores a pending hazard.
    step(1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 2, 6, 6, 1, 1, 0, 0, 0, 0, 0);
    idle(4);

    // Reset in the middle of a load-use stall.
    step(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    id_valid = 1; id_rd_we = 1; id_is_load = 0;
    id_rd = AW'(8); id_rs1 = '0; id_rs2 = AW'(7);
    id_rs1_used = 0; id_rs2_used = 1; flush = 0;
    @(negedge clk);
    chk("pre_rst stall", 32'(stall), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst stall", 32'(stall), 0);
    chk("mid_rst bubble", 32'(bubble), 0);
    chk("mid_rst f2", 32'(fwd_sel_rs2), 0);
`ifdef HAZ_STATS_EN
    chk("mid_rst sc", stall_cycles, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc++;
    base = cyc;
    exp_sc = 0;
    step(1, 1, 0, 8, 0, 7, 0, 1, 0, 0, 0, 0, 0);
    idle(4);

    // Random stream over a small register set for dense collisions.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(9, 0) != 0,
           $urandom_range(4, 0) != 0,
           $urandom_range(9, 0) < 3,
           $urandom_range(7, 0),
           $urandom_range(7, 0),
           $urandom_range(7, 0),
           $urandom_range(4, 0) != 0,
           $urandom_range(4, 0) != 0,
           $urandom_range(9, 0) == 0,
           -1, -1, -1, -1);
    end

`ifdef HAZ_STATS_EN
    chk("end sc", stall_cycles, exp_sc);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32: architectural register count; index 0 is hard-wired zero.
REQ-002 SHALL have parameter DEPTH, default 4: tracked stages beyond ID, numbered 1 (EXE) to DEPTH (WB).
REQ-003 SHALL have parameter ALU_LAT, default 1: first stage index at which an ALU result may be forwarded.
REQ-004 SHALL have parameter LOAD_LAT, default 2: first stage index at which load data may be forwarded; 1 <= ALU_LAT <= LOAD_LAT <= DEPTH.
REQ-005 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have ports id_valid, id_rd_we, id_is_load, input, 1 each: ID holds an instruction; it writes rd; it is a load.
REQ-008 SHALL have ports id_rd, id_rs1, id_rs2, input, clog2(NREG) each: ID destination and source addresses.
REQ-009 SHALL have ports id_rs1_used, id_rs2_used, input, 1 each: the source operand is consumed.
REQ-010 SHALL have port flush, input, 1: squash the ID instruction (taken branch).
REQ-011 SHALL have ports stall and bubble, output, 1 each: hold PC/IF-ID; insert NOP into ID-EXE.
REQ-012 SHALL have ports fwd_sel_rs1, fwd_sel_rs2, output, clog2(DEPTH+1) each: 0 = register file, k = stage k result bus.

Function
REQ-013 SHALL keep a shift register pipe[1..DEPTH] of entries {valid, we, ld, rd}, advancing every cycle without exception.
REQ-014 SHALL load pipe[1] with the ID instruction when id_valid & ~stall & ~flush; otherwise pipe[1] SHALL be an invalid entry.
REQ-015 SHALL force we=0 on entry when id_rd==0, so register 0 never matches.
REQ-016 SHALL match operand rsX against valid, we entries with rd==rsX, with priority to the youngest entry (lowest k).
REQ-017 SHALL set avail(k) = LOAD_LAT for ld entries and ALU_LAT otherwise.
REQ-018 SHALL assert stall=bubble=1, combinationally in the same cycle, when a used operand's youngest match sits at k < avail.
REQ-019 SHALL, otherwise, drive fwd_sel=k on a match and 0 on no match or an unused operand.
REQ-020 SHALL resolve flush over stall: stall=0, bubble=1, fwd_sel don't-care.
REQ-021 SHALL ignore all inputs when id_valid=0: stall=0, bubble=0, fwd_sel=0.
REQ-022 SHALL size the stall duration as avail-k cycles, releasing automatically as the producer advances; no counter beyond the pipe shift.
REQ-023 SHALL match the WB entry at k=DEPTH (forward from WB, no write-before-read reliance).

Reset
REQ-024 SHALL, when rst=0, asynchronously clear every pipe entry's valid bit, so stall, bubble and fwd_sel read 0.
REQ-025 SHALL discard all in-flight entries on reset mid-stall; no stall persists after rst releases.

Configuration
REQ-026 SHALL, with HAZ_STATS_EN defined, add output stall_cycles (32 bits), reset to 0, incrementing each cycle stall=1 and saturating at all ones.
REQ-027 SHALL, without HAZ_STATS_EN, omit the port and its counter.

Structure
REQ-028 SHALL take the entry struct, a stage-index typedef and the forwarding-select encoding from the shared package hz_pkg.
REQ-029 SHALL place the per-operand priority matcher in sub-module hz_match, instantiated once per source operand.

Verification
REQ-030 SHALL cover: ALU writes x5 in cycle n, ID reads rs1=x5 in n+1 -> no stall, fwd_sel_rs1=1.
REQ-031 SHALL cover: load to x7, next instruction uses rs2=x7 -> stall=bubble=1 for one cycle, then fwd_sel_rs2=2.
REQ-032 SHALL cover: ALU to x3 then load to x3, consumer of x3 -> youngest (load, k=1) wins, one-cycle stall, then fwd_sel=2.
REQ-033 SHALL cover: writer of x0 followed by reader of x0 -> fwd_sel=0, no stall.
REQ-034 SHALL cover: flush asserted during a load-use stall -> stall=0, bubble=1, and the next cycle pipe[1] is invalid.
REQ-035 SHALL cover: rst low during a stall with HAZ_STATS_EN -> outputs 0 immediately and stall_cycles=0.
